// File: rtl/tdm_slot_scheduler.sv
// TDM slot scheduler: strict time-division slots by default; work-conserving
// round-robin with a GAP cycle between grants when SKIP_IDLE_EN is defined.
module tdm_slot_scheduler #(
  parameter int N        = 4,
  parameter int SLOT_LEN = 8,
  parameter int PTR_W    = 2,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] slot,
  output logic             busy
);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SLOT_LEN - 1);

  logic [PTR_W-1:0] slot_q;
  logic [CNT_W-1:0] timer_q;
  logic [N-1:0]     gnt_int;

  function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + 1'b1;
  endfunction

`ifdef SKIP_IDLE_EN

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] slot_d;
  logic [CNT_W-1:0] timer_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             found;
  logic [PTR_W-1:0] found_idx;
  logic             grant_end;

  // Round-robin search starting at slot_q; the smallest offset wins.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    found_idx = slot_q;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(slot_q) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        found     = 1'b1;
        found_idx = PTR_W'(idx);
      end
    end
  end

  assign grant_end = (timer_q == LAST_TICK) || done[slot_q] || !req[slot_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
    end
  end

  // GAP resolves the next grant itself so only one zero cycle separates grants.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    timer_d = timer_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE, GAP: begin
        gnt_d   = '0;
        timer_d = '0;
        state_d = IDLE;
        if (found) begin
          slot_d           = found_idx;
          gnt_d[found_idx] = 1'b1;
          state_d          = GRANT;
        end
      end
      GRANT: begin
        if (grant_end) begin
          gnt_d   = '0;
          timer_d = '0;
          slot_d  = next_slot(slot_q);
          state_d = GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_int = gnt_q;

`else

  logic done_lat_q;
  logic slot_wrap;

  assign slot_wrap = (timer_q == LAST_TICK);

  // Timer free-runs; every slot lasts SLOT_LEN cycles whether used or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= '0;
      slot_q     <= '0;
      done_lat_q <= 1'b0;
    end else if (slot_wrap) begin
      timer_q    <= '0;
      slot_q     <= next_slot(slot_q);
      done_lat_q <= 1'b0;
    end else begin
      timer_q <= timer_q + 1'b1;
      if (done[slot_q]) done_lat_q <= 1'b1;
    end
  end

  always_comb begin
    gnt_int         = '0;
    gnt_int[slot_q] = req[slot_q] & ~done_lat_q;
  end

`endif

  assign gnt  = reset ? '0 : gnt_int;
  assign slot = reset ? '0 : slot_q;
  assign busy = |gnt;

endmodule
